// File: rtl/decode_pkg.sv
// Shared encodings and defaults for the decode/issue stage.
// Bypass of same-cycle writebacks is enabled by defining DECODE_BYPASS_EN.
package decode_pkg;

    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_REG_WIDTH = 32;
    localparam int DEF_NUM_WB    = 2;
    localparam int DEF_PAYLOAD_W = 48;

    // Condition code is {N,Z,P}; the register file starts out "zero".
    localparam logic [2:0] CC_N     = 3'b100;
    localparam logic [2:0] CC_Z     = 3'b010;
    localparam logic [2:0] CC_P     = 3'b001;
    localparam logic [2:0] CC_RESET = CC_Z;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_BRANCH = 1'b1
    } state_t;

endpackage

// File: rtl/decode_scoreboard_bits.sv
// Per-register pending bits: one set port from issue, NUM_WB clear ports from
// writeback. A set and a clear on the same index in one cycle leaves it set.
module decode_scoreboard_bits
    import decode_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_WB   = DEF_NUM_WB,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    set_en,
    input  logic [IDX_W-1:0]        set_idx,
    input  logic [NUM_WB-1:0]       clr_en,
    input  logic [NUM_WB*IDX_W-1:0] clr_idx,
    output logic [NUM_REGS-1:0]     pend
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        for (int p = 0; p < NUM_WB; p++) begin
            if (clr_en[p]) begin
                pend_d[clr_idx[p*IDX_W +: IDX_W]] = 1'b0;
            end
        end
        if (set_en) begin
            pend_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/decode_scoreboard.sv
// Decode/issue stage: register file, pending scoreboard, CC scoreboard and
// branch-hold FSM. Define DECODE_BYPASS_EN to forward same-cycle writebacks.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int NUM_WB    = DEF_NUM_WB,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                        I_CLOCK,
    input  logic                        I_RESET_N,
    input  logic                        I_FE_Valid,
    input  logic [PAYLOAD_W-1:0]        I_Payload,
    input  logic [IDX_W-1:0]            I_Src1Idx,
    input  logic [IDX_W-1:0]            I_Src2Idx,
    input  logic                        I_Src1Use,
    input  logic                        I_Src2Use,
    input  logic [IDX_W-1:0]            I_DestIdx,
    input  logic                        I_DestWrite,
    input  logic                        I_CCRead,
    input  logic                        I_CCWrite,
    input  logic                        I_IsBranch,
    input  logic                        I_GPUStallSignal,
    input  logic [NUM_WB-1:0]           I_WB_En,
    input  logic [NUM_WB*IDX_W-1:0]     I_WB_Idx,
    input  logic [NUM_WB*REG_WIDTH-1:0] I_WB_Data,
    input  logic                        I_WB_CCEn,
    input  logic [2:0]                  I_WB_CCValue,
    input  logic                        I_WriteBackPCEn,
    output logic                        O_DE_Valid,
    output logic [PAYLOAD_W-1:0]        O_Payload,
    output logic [REG_WIDTH-1:0]        O_Src1Value,
    output logic [REG_WIDTH-1:0]        O_Src2Value,
    output logic [IDX_W-1:0]            O_DestIdx,
    output logic                        O_DestWrite,
    output logic [2:0]                  O_CCValue,
    output logic                        O_DepStallSignal,
    output logic                        O_BranchStallSignal,
    output state_t                      O_DbgState,
    output logic [NUM_REGS-1:0]         O_DbgPend,
    output logic                        O_DbgCCPend
);

    state_t                 state_q, state_d;
    logic [REG_WIDTH-1:0]   rf_q [NUM_REGS];
    logic [REG_WIDTH-1:0]   rf_d [NUM_REGS];
    logic [NUM_REGS-1:0]    pend;
    logic                   cc_pend_q, cc_pend_d;
    logic [2:0]             cc_q, cc_d;

    logic                   de_valid_q, de_valid_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic [REG_WIDTH-1:0]   src1_q, src1_d;
    logic [REG_WIDTH-1:0]   src2_q, src2_d;
    logic [IDX_W-1:0]       dest_idx_q, dest_idx_d;
    logic                   dest_write_q, dest_write_d;
    logic [2:0]             cc_out_q, cc_out_d;

    logic                   src1_pend, src2_pend, dest_pend, cc_rd_pend;
    logic [REG_WIDTH-1:0]   src1_val, src2_val;
    logic [2:0]             cc_val;
    logic                   dep, accept;

    // Operand lookup and hazard detection.
    always_comb begin
        src1_pend  = I_Src1Use & pend[I_Src1Idx];
        src2_pend  = I_Src2Use & pend[I_Src2Idx];
        src1_val   = rf_q[I_Src1Idx];
        src2_val   = rf_q[I_Src2Idx];
        cc_rd_pend = I_CCRead & cc_pend_q;
        cc_val     = cc_q;
`ifdef DECODE_BYPASS_EN
        // Ascending scan so the highest-numbered matching port wins.
        for (int p = 0; p < NUM_WB; p++) begin
            if (I_WB_En[p] && (I_WB_Idx[p*IDX_W +: IDX_W] == I_Src1Idx)) begin
                src1_pend = 1'b0;
                src1_val  = I_WB_Data[p*REG_WIDTH +: REG_WIDTH];
            end
            if (I_WB_En[p] && (I_WB_Idx[p*IDX_W +: IDX_W] == I_Src2Idx)) begin
                src2_pend = 1'b0;
                src2_val  = I_WB_Data[p*REG_WIDTH +: REG_WIDTH];
            end
        end
        if (I_WB_CCEn) begin
            cc_rd_pend = 1'b0;
            cc_val     = I_WB_CCValue;
        end
`endif
        // Destination check blocks WAW; it is never bypassed.
        dest_pend = I_DestWrite & pend[I_DestIdx];
        dep       = I_FE_Valid & (src1_pend | src2_pend | dest_pend | cc_rd_pend);
        accept    = I_FE_Valid & ~dep & (state_q == S_RUN) & ~I_GPUStallSignal;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (accept && I_IsBranch) state_d = S_BRANCH;
            S_BRANCH: if (I_WriteBackPCEn)      state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    // Writeback commits even under downstream stall; highest port wins data.
    always_comb begin
        rf_d = rf_q;
        for (int p = 0; p < NUM_WB; p++) begin
            if (I_WB_En[p]) begin
                rf_d[I_WB_Idx[p*IDX_W +: IDX_W]] = I_WB_Data[p*REG_WIDTH +: REG_WIDTH];
            end
        end
        cc_d      = I_WB_CCEn ? I_WB_CCValue : cc_q;
        cc_pend_d = cc_pend_q;
        if (I_WB_CCEn) cc_pend_d = 1'b0;
        if (accept && I_CCWrite) cc_pend_d = 1'b1;
    end

    always_comb begin
        de_valid_d   = de_valid_q;
        payload_d    = payload_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        dest_idx_d   = dest_idx_q;
        dest_write_d = dest_write_q;
        cc_out_d     = cc_out_q;
        if (accept) begin
            de_valid_d   = 1'b1;
            payload_d    = I_Payload;
            src1_d       = src1_val;
            src2_d       = src2_val;
            dest_idx_d   = I_DestIdx;
            dest_write_d = I_DestWrite;
            cc_out_d     = cc_val;
        end else if (!I_GPUStallSignal) begin
            de_valid_d = 1'b0;
        end
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q      <= S_RUN;
            cc_q         <= CC_RESET;
            cc_pend_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            de_valid_q   <= 1'b0;
            payload_q    <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            dest_idx_q   <= '0;
            dest_write_q <= 1'b0;
            cc_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            cc_q         <= cc_d;
            cc_pend_q    <= cc_pend_d;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= rf_d[i];
            de_valid_q   <= de_valid_d;
            payload_q    <= payload_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            dest_idx_q   <= dest_idx_d;
            dest_write_q <= dest_write_d;
            cc_out_q     <= cc_out_d;
        end
    end

    decode_scoreboard_bits #(
        .NUM_REGS (NUM_REGS),
        .NUM_WB   (NUM_WB),
        .IDX_W    (IDX_W)
    ) u_bits (
        .clk     (I_CLOCK),
        .rst_n   (I_RESET_N),
        .set_en  (accept & I_DestWrite),
        .set_idx (I_DestIdx),
        .clr_en  (I_WB_En),
        .clr_idx (I_WB_Idx),
        .pend    (pend)
    );

    assign O_DE_Valid          = de_valid_q;
    assign O_Payload           = payload_q;
    assign O_Src1Value         = src1_q;
    assign O_Src2Value         = src2_q;
    assign O_DestIdx           = dest_idx_q;
    assign O_DestWrite         = dest_write_q;
    assign O_CCValue           = cc_out_q;
    assign O_DepStallSignal    = dep;
    assign O_BranchStallSignal = (state_q == S_BRANCH) | (I_FE_Valid & I_IsBranch & accept);
    assign O_DbgState          = state_q;
    assign O_DbgPend           = pend;
    assign O_DbgCCPend         = cc_pend_q;

endmodule
